// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants: FSM state encoding, NOP word, output payload.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } fetch_word_t;

    localparam fetch_word_t RESET_WORD = fetch_word_t'{NOP_INSTR, 32'h0000_0000, 32'h0000_0004};

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: imem port, redirect input, decode handshake, status.
// FETCH_MISALIGN_TRAP_EN adds the misalign status line.
interface fetch_unit_if;
    import riscv_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_plus4;
    logic            halted;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misalign;
`endif

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_target,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc_plus4,
        output halted
`ifdef FETCH_MISALIGN_TRAP_EN
        , output misalign
`endif
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_target,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4,
        input  halted
`ifdef FETCH_MISALIGN_TRAP_EN
        , input misalign
`endif
    );

endinterface

// File: rtl/fetch_out_reg.sv
// Valid/ready output register for fetched words; flush drops the held word.
module fetch_out_reg
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        load,
    input  fetch_word_t din,
    input  logic        ready,
    output logic        valid,
    output fetch_word_t dout
);

    // Flush beats load; a consumed word without a replacement clears valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= RESET_WORD;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: BOOT/RUN/HALT FSM driving a PC into imem and a valid/ready output stage.
// FETCH_MISALIGN_TRAP_EN: misaligned redirects trap into HALT instead of being aligned.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 64
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);

    localparam logic [1:0]      ST_BOOT  = 2'(BOOT);
    localparam logic [1:0]      ST_RUN   = 2'(RUN);
    localparam logic [1:0]      ST_HALT  = 2'(HALT);
    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_WORDS * 4);

    logic [1:0]      state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic            halted_q;
    logic            load, flush, free;
    logic            out_valid;
    fetch_word_t     din, dout;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misalign_q, misalign_next;
`endif

    assign free = !out_valid || bus.out_ready;

    assign din.instr    = bus.imem_rdata;
    assign din.pc       = pc;
    assign din.pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            pc       <= RESET_PC;
            halted_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            halted_q <= (state_next == ST_HALT);
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_next;
`endif
        end
    end

    // Redirect overrides everything, including the BOOT cycle and HALT.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        load       = 1'b0;
        flush      = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_next = 1'b0;
`endif
        if (bus.redirect_valid) begin
            flush = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (bus.redirect_target[1:0] != 2'b00) begin
                misalign_next = 1'b1;
                state_next    = ST_HALT;
            end else begin
                pc_next    = bus.redirect_target;
                state_next = ST_RUN;
            end
`else
            pc_next    = bus.redirect_target & ~32'h0000_0003;
            state_next = ST_RUN;
`endif
        end else begin
            case (state)
                ST_BOOT: state_next = ST_RUN;
                ST_RUN: begin
                    if (pc >= PC_LIMIT) begin
                        state_next = ST_HALT;
                    end else if (free) begin
                        load    = 1'b1;
                        pc_next = pc + 32'd4;
                    end
                end
                ST_HALT: state_next = ST_HALT;
                default: state_next = ST_BOOT;
            endcase
        end
    end

    fetch_out_reg u_out_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .load  (load),
        .din   (din),
        .ready (bus.out_ready),
        .valid (out_valid),
        .dout  (dout)
    );

    assign bus.imem_addr    = pc;
    assign bus.out_valid    = out_valid;
    assign bus.out_instr    = dout.instr;
    assign bus.out_pc       = dout.pc;
    assign bus.out_pc_plus4 = dout.pc_plus4;
    assign bus.halted       = halted_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.misalign     = misalign_q;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 64, the instruction memory depth in 32-bit words; legal PC range is 0 .. IMEM_WORDS*4-4.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port imem_addr, output, 32, the byte address driven to instruction memory; always equal to the current PC, combinational from the PC register.
REQ-006 SHALL have port imem_rdata, input, 32, the instruction word returned combinationally in the same cycle for imem_addr.
REQ-007 SHALL have port redirect_valid, input, 1, a branch/jump taken this cycle.
REQ-008 SHALL have port redirect_target, input, 32, the new PC, valid when redirect_valid is 1.
REQ-009 SHALL have port out_valid, output, 1, a fetched instruction is held on out_*.
REQ-010 SHALL have port out_ready, input, 1, the decode stage accepts the out_* word this cycle.
REQ-011 SHALL have port out_instr, output, 32, the fetched instruction.
REQ-012 SHALL have port out_pc, output, 32, the address of out_instr.
REQ-013 SHALL have port out_pc_plus4, output, 32, out_pc+4, computed modulo 2^32.
REQ-014 SHALL have port halted, output, 1, 1 while the FSM is in HALT.

Function
REQ-015 SHALL implement the FSM states BOOT, RUN, and HALT; BOOT lasts exactly one cycle after reset release, then moves to RUN; no fetch occurs in BOOT.
REQ-016 In RUN, the output register SHALL be "free" when out_valid==0 or out_ready==1.
REQ-017 In RUN with the output register free and no redirect, the block SHALL capture out_instr=imem_rdata and out_pc=PC, set out_valid=1, and set PC<=PC+4; latency is 1 cycle from PC to out_valid.
REQ-018 When out_valid==1 and out_ready==0, out_* and PC SHALL hold unchanged, with no drop and no duplicate.
REQ-019 When out_ready==1 and no new word is captured, out_valid SHALL fall to 0 in the next cycle.
REQ-020 redirect_valid SHALL have top priority in every state: next cycle PC=redirect_target, out_valid=0 (the in-flight word is flushed even if out_ready==0), and the state is RUN; no word is captured in the redirect cycle.
REQ-021 If in RUN the PC is at or above IMEM_WORDS*4, the FSM SHALL go to HALT with no capture; any already-held valid word still drains through the normal handshake.
REQ-022 In HALT, no capture SHALL occur and the PC SHALL hold; only a redirect or reset exits HALT.
REQ-023 PC+4 SHALL wrap modulo 2^32; a wrap is unreachable in practice because REQ-021 triggers first.

Reset
REQ-024 While rst_n==0 at a clock edge: PC=RESET_PC, state=BOOT, out_valid=0, out_instr=32'h0000_0013 (NOP), out_pc=0, out_pc_plus4=4, halted=0, misalign=0.
REQ-025 A reset asserted mid-handshake SHALL discard the held word with no partial state.

Configuration
REQ-026 Macro FETCH_MISALIGN_TRAP_EN defined: the block SHALL add output port misalign, 1 bit; a redirect with target[1:0]!=0 SHALL pulse misalign for one cycle, leave the PC unchanged, flush out_valid, and enter HALT.
REQ-027 Macro FETCH_MISALIGN_TRAP_EN undefined: there SHALL be no misalign port; redirect_target[1:0] SHALL be forced to 00 on load.

Structure
REQ-028 The shared package (riscv_pkg) SHALL hold: the FSM state enum fetch_state_t {BOOT, RUN, HALT}, the constant NOP_INSTR=32'h0000_0013, and the constant XLEN=32.
REQ-029 There SHALL be a single sub-module, fetch_out_reg, that holds the valid/ready output register (instr, pc, pc_plus4) with a flush input.

Verification
REQ-030 Scenario: reset release, imem holds the addi program, out_ready=1 -> out_valid first at cycle 2 with out_pc=0, out_instr=32'h00500093; then out_pc=4, 8, ... one per cycle.
REQ-031 Scenario: hold out_ready=0 for 3 cycles while out_pc=8 -> out_pc=8 and out_instr=32'h002081B3 are stable; after release, the next word is out_pc=12 with no gap or duplicate.
REQ-032 Scenario: redirect_valid=1, target=40, while out_valid=1 and out_ready=0 -> next cycle out_valid=0; the cycle after, out_pc=40, out_instr=32'h00900493.
REQ-033 Scenario: run to PC=252 with IMEM_WORDS=64 -> the word at 252 is delivered, then halted=1 with no further out_valid; redirect to 0 -> RUN, and out_pc=0 is delivered.
REQ-034 Scenario: redirect target=42 -> with the macro, misalign pulses 1 cycle and halted=1; without the macro, out_pc=40 is delivered.
REQ-035 Scenario: rst_n=0 asserted while out_valid=1 -> next cycle out_valid=0 and PC=RESET_PC; one BOOT cycle follows before the next fetch.
